hazard_ctrl: RTL

Pipeline hazard controller for the 5-stage core. It tracks the destination register, write-enable and load flag of every in-flight instruction in EX, MEM and WB, and from that state drives the pipeline control signals. It generates load-use stalls, taken-branch flushes, data-memory wait freezes and operand-forwarding selects for the EX stage. It sits beside the ID stage, is fed from the decoded control word (rd, rf_en, load/store op), and steers the IF/ID and ID/EX pipeline registers.

---
 rtl/hazard_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks EX/MEM/WB destinations and drives load-use
// stalls, branch flushes, memory-wait freezes and EX operand forwarding selects.
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       id_rd,
  input  logic             id_rf_en,
  input  logic             id_is_load,
  input  logic             ex_br_taken,
  input  logic             mem_busy,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             flush_id,
  output logic             freeze,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] lu_stall_cnt
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       rf_en;
    logic       is_load;
  } stage_t;

  typedef struct packed {
    stage_t     st;
    logic [4:0] rs1;
    logic       rs1_used;
    logic [4:0] rs2;
    logic       rs2_used;
  } ex_t;

  ex_t              ex_q, ex_d;
  stage_t           mem_q, mem_d;
  stage_t           wb_q, wb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu;

  function automatic logic hz_match(input stage_t s, input logic [4:0] r);
    return s.valid && s.rf_en && (s.rd == r) && (r != 5'd0);
  endfunction

  // A load in MEM has no data yet, so it never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] r, input logic used,
                                         input stage_t m, input stage_t w);
    logic [1:0] sel;
    sel = 2'b00;
    if (used) begin
      if (hz_match(m, r) && !m.is_load) begin
        sel = 2'b01;
      end else if (hz_match(w, r)) begin
        sel = 2'b10;
      end
    end
    return sel;
  endfunction

  always_comb begin
    lu = id_valid && ex_q.st.is_load &&
         ((id_rs1_used && hz_match(ex_q.st, id_rs1)) ||
          (id_rs2_used && hz_match(ex_q.st, id_rs2)));
  end

  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    freeze    = 1'b0;
    fwd_a_sel = 2'b00;
    fwd_b_sel = 2'b00;
    if (rst) begin
      // Tracking is treated as empty while reset is held.
      flush_id = ex_br_taken;
      freeze   = mem_busy;
    end else begin
      if (mem_busy) begin
        freeze   = 1'b1;
        stall_if = 1'b1;
        stall_id = 1'b1;
      end else if (ex_br_taken) begin
        flush_id  = 1'b1;
        bubble_ex = 1'b1;
      end else if (lu) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
      end
      if (ex_q.st.valid) begin
        fwd_a_sel = fwd_sel(ex_q.rs1, ex_q.rs1_used, mem_q, wb_q);
        fwd_b_sel = fwd_sel(ex_q.rs2, ex_q.rs2_used, mem_q, wb_q);
      end
    end
  end

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    cnt_d = cnt_q;
    if (!mem_busy) begin
      wb_d           = mem_q;
      mem_d          = ex_q.st;
      ex_d.st.valid  = id_valid && !bubble_ex;
      ex_d.st.rd     = id_rd;
      ex_d.st.rf_en  = id_rf_en;
      ex_d.st.is_load = id_is_load;
      ex_d.rs1       = id_rs1;
      ex_d.rs1_used  = id_rs1_used;
      ex_d.rs2       = id_rs2;
      ex_d.rs2_used  = id_rs2_used;
      if (lu && !ex_br_taken && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  assign lu_stall_cnt = cnt_q;

endmodule
